video_dram_timing_controller: RTL

VIDEO_DRAM_TIMING_CONTROLLER -- requirements
Module: video_dram_timing_controller

---
 rtl/video_dram_pkg.sv | 18 +
 rtl/video_dram_timing_controller.sv | 159 +++++++++++++++
 2 files changed

// File: rtl/video_dram_pkg.sv
// Shared types and constants for the video DRAM timing controller.
package video_dram_pkg;

  localparam int ROW_BITS   = 7;
  localparam int ADDR_BITS  = 14;
  localparam int REF_CYCLES = 2;
  localparam int CNT_W      = 2;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    ROW     = 3'd1,
    COL     = 3'd2,
    PRE     = 3'd3,
    REF_ROW = 3'd4,
    REF_PRE = 3'd5
  } state_t;

endpackage

// File: rtl/video_dram_timing_controller.sv
// DRAM strobe/address sequencer arbitrating refresh, video fetch and blitter accesses.
// Request/ack semantics: a request high on any CLK edge sets (or merges into) its pending flag;
// the matching ACK pulses for one clock in the last CAS clock of the access serving it.
module video_dram_timing_controller
  import video_dram_pkg::*;
#(
  parameter int CAS_CYCLES = 2,
  parameter int PRE_CYCLES = 1
) (
  input  logic                 CLK,
  input  logic                 RESET_AL,
  input  logic                 VID_REQ,
  input  logic [ADDR_BITS-1:0] AVAX,
  input  logic                 BLT_REQ,
  input  logic [ADDR_BITS-1:0] AVBX,
  input  logic                 BLT_WE,
  input  logic                 REFRESH_TICK,
  output logic [ROW_BITS-1:0]  MA,
  output logic                 RAS_AL,
  output logic                 CAS_AL,
  output logic                 WE_AL,
  output logic                 VID_ACK,
  output logic                 BLT_ACK,
  output logic                 BUSY,
  output state_t               DBG_STATE
);

  localparam logic [CNT_W-1:0] CAS_LAST = CNT_W'(CAS_CYCLES - 1);
  localparam logic [CNT_W-1:0] PRE_LAST = CNT_W'(PRE_CYCLES - 1);
  localparam logic [CNT_W-1:0] REF_LAST = CNT_W'(REF_CYCLES - 1);

  state_t               r_state, w_next;
  logic [CNT_W-1:0]     r_cnt, w_cnt_next;
  logic                 r_ref_pend, r_vid_pend, r_blt_pend;
  logic [ADDR_BITS-1:0] r_vid_addr, r_blt_addr, r_cur_addr, w_cur_addr;
  logic                 r_blt_we, r_cur_blt, r_cur_we, w_cur_blt, w_cur_we;
  logic                 w_sel_blt;
  logic [ROW_BITS-1:0]  r_ref_cnt, r_ma;
  logic                 r_ras_al, r_cas_al, r_we_al, r_vid_ack, r_blt_ack;
  logic                 w_acc_done, w_ref_done, w_vid_clr, w_blt_clr;

  assign w_acc_done = (r_state == COL) && (r_cnt == CAS_LAST);
  assign w_ref_done = (r_state == REF_ROW) && (r_cnt == REF_LAST);
  assign w_vid_clr  = w_acc_done && !r_cur_blt;
  assign w_blt_clr  = w_acc_done && r_cur_blt;

  // Same-edge requests are considered in IDLE, so arbitration looks through the flags.
  always_comb begin
    w_next    = r_state;
    w_sel_blt = 1'b0;
    case (r_state)
      IDLE: begin
        if (r_ref_pend || REFRESH_TICK)  w_next = REF_ROW;
        else if (r_vid_pend || VID_REQ)  w_next = ROW;
        else if (r_blt_pend || BLT_REQ) begin
          w_next    = ROW;
          w_sel_blt = 1'b1;
        end
      end
      ROW:     w_next = COL;
      COL:     if (w_acc_done) w_next = PRE;
      PRE:     if (r_cnt == PRE_LAST) w_next = IDLE;
      REF_ROW: if (w_ref_done) w_next = REF_PRE;
      REF_PRE: if (r_cnt == PRE_LAST) w_next = IDLE;
      default: w_next = IDLE;
    endcase
    w_cnt_next = (w_next == r_state) ? r_cnt + {{(CNT_W-1){1'b0}}, 1'b1} : '0;
  end

  always_comb begin
    w_cur_addr = r_cur_addr;
    w_cur_blt  = r_cur_blt;
    w_cur_we   = r_cur_we;
    if (r_state == IDLE) begin
      w_cur_blt = w_sel_blt;
      if (w_sel_blt) begin
        w_cur_addr = r_blt_pend ? r_blt_addr : AVBX;
        w_cur_we   = r_blt_pend ? r_blt_we : BLT_WE;
      end else begin
        w_cur_addr = r_vid_pend ? r_vid_addr : AVAX;
        w_cur_we   = 1'b0;
      end
    end
  end

  always_ff @(posedge CLK or negedge RESET_AL) begin
    if (!RESET_AL) begin
      r_state    <= IDLE;
      r_cnt      <= '0;
      r_ref_pend <= 1'b0;
      r_vid_pend <= 1'b0;
      r_blt_pend <= 1'b0;
      r_vid_addr <= '0;
      r_blt_addr <= '0;
      r_blt_we   <= 1'b0;
      r_cur_addr <= '0;
      r_cur_blt  <= 1'b0;
      r_cur_we   <= 1'b0;
      r_ref_cnt  <= '0;
    end else begin
      r_state    <= w_next;
      r_cnt      <= w_cnt_next;
      r_cur_addr <= w_cur_addr;
      r_cur_blt  <= w_cur_blt;
      r_cur_we   <= w_cur_we;
      // A flag that clears on this edge is free to be re-armed by a request on the same edge.
      if (REFRESH_TICK && (!r_ref_pend || w_ref_done)) r_ref_pend <= 1'b1;
      else if (w_ref_done)                              r_ref_pend <= 1'b0;
      if (VID_REQ && (!r_vid_pend || w_vid_clr)) begin
        r_vid_pend <= 1'b1;
        r_vid_addr <= AVAX;
      end else if (w_vid_clr) begin
        r_vid_pend <= 1'b0;
      end
      if (BLT_REQ && (!r_blt_pend || w_blt_clr)) begin
        r_blt_pend <= 1'b1;
        r_blt_addr <= AVBX;
        r_blt_we   <= BLT_WE;
      end else if (w_blt_clr) begin
        r_blt_pend <= 1'b0;
      end
      if (w_ref_done) r_ref_cnt <= r_ref_cnt + 7'd1;
    end
  end

  // Strobes are decoded from the next state so they change on the same edge as the FSM.
  always_ff @(posedge CLK or negedge RESET_AL) begin
    if (!RESET_AL) begin
      r_ma      <= '0;
      r_ras_al  <= 1'b1;
      r_cas_al  <= 1'b1;
      r_we_al   <= 1'b1;
      r_vid_ack <= 1'b0;
      r_blt_ack <= 1'b0;
    end else begin
      r_ras_al  <= !((w_next == ROW) || (w_next == COL) || (w_next == REF_ROW));
      r_cas_al  <= !(w_next == COL);
      r_we_al   <= !((w_next == COL) && w_cur_blt && w_cur_we);
      r_vid_ack <= (w_next == COL) && (w_cnt_next == CAS_LAST) && !w_cur_blt;
      r_blt_ack <= (w_next == COL) && (w_cnt_next == CAS_LAST) && w_cur_blt;
      case (w_next)
        ROW:     r_ma <= w_cur_addr[ROW_BITS-1:0];
        COL:     r_ma <= w_cur_addr[ADDR_BITS-1:ROW_BITS];
        REF_ROW: r_ma <= r_ref_cnt;
        default: r_ma <= r_ma;
      endcase
    end
  end

  assign MA        = r_ma;
  assign RAS_AL    = r_ras_al;
  assign CAS_AL    = r_cas_al;
  assign WE_AL     = r_we_al;
  assign VID_ACK   = r_vid_ack;
  assign BLT_ACK   = r_blt_ack;
  assign BUSY      = (r_state != IDLE);
  assign DBG_STATE = r_state;

endmodule
